// File: rtl/fifo_vc.sv
// fifo_vc: per-channel synchronous FIFO buffer with occupancy, threshold and sticky error flags.
module fifo_vc #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   almost_full_th,
    input  logic [ADDR_WIDTH:0]   almost_empty_th,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    logic                  err_evt;

    // Status flags decoded from the registered occupancy count.
    always_comb begin
        empty        = (count == '0);
        full         = (count == CW'(DEPTH));
        almost_full  = (count >= almost_full_th);
        almost_empty = (count <= almost_empty_th);
    end

    // Accept logic: a pop on a full FIFO frees the slot the concurrent push lands in.
    always_comb begin
        rd_en   = pop && !empty;
        wr_en   = push && (!full || pop);
        err_evt = (push && full && !pop) || (pop && empty);
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, registered read data and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                data_out  <= mem[rd_ptr];
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (err_evt) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_vc.sv
// tb_fifo_vc: directed stimulus, queue-based reference model and per-cycle comparison for fifo_vc.
module tb_fifo_vc;

    localparam int unsigned DW    = 6;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [AW:0]   almost_full_th;
    logic [AW:0]   almost_empty_th;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          error;

    int checks = 0;
    int errors = 0;

    fifo_vc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .data_in         (data_in),
        .pop             (pop),
        .almost_full_th  (almost_full_th),
        .almost_empty_th (almost_empty_th),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .empty           (empty),
        .full            (full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .count           (count),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus the observable registers.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    bit            m_valid;
    bit            m_err;
    bit            armed = 1'b0;
    bit            m_pop_ok;
    bit            m_push_ok;

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            m_pop_ok  = pop && (m_q.size() > 0);
            m_push_ok = push && ((m_q.size() < DEPTH) || m_pop_ok);
            if (m_pop_ok) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_push_ok) m_q.push_back(data_in);
            if ((push && !m_push_ok) || (pop && !m_pop_ok)) m_err = 1'b1;
        end
    end

    // Compare every observable output against the model, mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            chk("count",        32'(count),        32'(m_q.size()));
            chk("empty",        32'(empty),        32'(m_q.size() == 0));
            chk("full",         32'(full),         32'(m_q.size() == DEPTH));
            chk("almost_full",  32'(almost_full),  32'(m_q.size() >= int'(almost_full_th)));
            chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= int'(almost_empty_th)));
            chk("error",        32'(error),        32'(m_err));
            chk("valid_out",    32'(valid_out),    32'(m_valid));
            chk("data_out",     32'(data_out),     32'(m_dout));
        end
    end

    // One clock: drive inputs, wait for the edge, settle just after it.
    task automatic tick(input logic p, input logic [DW-1:0] d, input logic po);
        push    = p;
        data_in = d;
        pop     = po;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] fill_w [4];
    logic [DW-1:0] wrap_w [4];
    bit            ae_exp [5];
    bit            af_exp [5];

    initial begin
        fill_w = '{6'h11, 6'h22, 6'h33, 6'h04};
        wrap_w = '{6'h20, 6'h30, 6'h0F, 6'h2A};
        ae_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        af_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset           = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        data_in         = '0;
        almost_full_th  = 3'd3;
        almost_empty_th = 3'd1;
        @(negedge clk);

        // Reset for two cycles then check the reset state.
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_dout",  32'(data_out),  32'd0);
        chk("rst_err",   32'(error),     32'd0);
        chk("thr_ae0",   32'(almost_empty), 32'(ae_exp[0]));
        chk("thr_af0",   32'(almost_full),  32'(af_exp[0]));
        reset = 1'b1;

        // Fill, stepping the thresholds through count 1..4.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, fill_w[i], 1'b0);
            chk("thr_ae", 32'(almost_empty), 32'(ae_exp[i+1]));
            chk("thr_af", 32'(almost_full),  32'(af_exp[i+1]));
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full",  32'(full),  32'd1);

        // Overflow: word dropped, error set.
        tick(1'b1, 6'h3F, 1'b0);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_err",   32'(error), 32'd1);

        // Drain back-to-back; original words in order.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1);
            chk("drain_dout",  32'(data_out),  32'(fill_w[i]));
            chk("drain_valid", 32'(valid_out), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        tick(1'b0, '0, 1'b0);
        chk("hold_valid", 32'(valid_out), 32'd0);
        chk("hold_dout",  32'(data_out),  32'h04);

        // Push and pop together on empty: push accepted, pop rejected.
        tick(1'b1, 6'h05, 1'b1);
        chk("udf_count", 32'(count),     32'd1);
        chk("udf_valid", 32'(valid_out), 32'd0);
        chk("udf_err",   32'(error),     32'd1);
        tick(1'b0, '0, 1'b1);
        chk("udf_pop",   32'(data_out),  32'h05);

        // Clear error, then full simultaneous push/pop and wrap.
        reset = 1'b0;
        tick(1'b0, '0, 1'b0);
        reset = 1'b1;
        tick(1'b1, 6'h10, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, wrap_w[i], 1'b0);
        chk("wrap_full", 32'(full), 32'd1);
        tick(1'b1, 6'h2A, 1'b1);
        chk("fsim_count", 32'(count),    32'd4);
        chk("fsim_err",   32'(error),    32'd0);
        chk("fsim_dout",  32'(data_out), 32'h10);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1);
            chk("wrap_dout", 32'(data_out), 32'(wrap_w[i]));
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Thresholds above depth pin the flags.
        almost_full_th  = 3'd7;
        almost_empty_th = 3'd5;
        for (int i = 0; i < 3; i++) tick(1'b1, 6'(i + 1), 1'b0);
        chk("hith_af", 32'(almost_full),  32'd0);
        chk("hith_ae", 32'(almost_empty), 32'd1);
        almost_full_th  = 3'd3;
        almost_empty_th = 3'd1;

        // Reset mid-operation with pop asserted.
        reset = 1'b0;
        tick(1'b0, '0, 1'b1);
        chk("mrst_count", 32'(count),     32'd0);
        chk("mrst_valid", 32'(valid_out), 32'd0);
        chk("mrst_dout",  32'(data_out),  32'd0);
        chk("mrst_empty", 32'(empty),     32'd1);
        chk("mrst_err",   32'(error),     32'd0);
        reset = 1'b1;

        // Mixed traffic checked only by the model.
        for (int i = 0; i < 24; i++) tick(1'(i % 3 != 2), 6'(i * 7), 1'(i % 2));
        tick(1'b0, '0, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_vc.md
# fifo_vc

Parameterised synchronous FIFO forming the per-channel buffer stage around the arbiter. Four instances sit upstream of the arbiter and are drained through its pop0–pop3 strobes. Four more sit downstream and are filled through push4–push7, feeding back full4–full7. Each instance stores routed words in a circular buffer and reports occupancy, empty/full, programmable almost-empty/almost-full thresholds, and a sticky error flag.

## Interface
Parameters:
- DATA_WIDTH, 6, word width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the 2-bit destination field.
- ADDR_WIDTH, 2, pointer width. Depth = 2**ADDR_WIDTH (4 by default).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- push  input  1  write request; data_in is sampled on the same edge.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- almost_full_th  input  ADDR_WIDTH+1  almost-full threshold, quasi-static.
- almost_empty_th  input  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_WIDTH.
- almost_full  output  1  count >= almost_full_th.
- almost_empty  output  1  count <= almost_empty_th.
- count  output  ADDR_WIDTH+1  current occupancy.
- error  output  1  sticky overflow/underflow flag.

## Operation
- Storage: memory array of depth 2**ADDR_WIDTH. Write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits, wrap modulo depth with no special case. The register count is the single source of truth for occupancy.
- Reset, sampled when reset=0 on a clock edge:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1 (any threshold ≥ 0), almost_full=(almost_full_th==0).
  - Memory contents are not cleared.
  - Reset has priority over push and pop on the same edge. A pop in that cycle is discarded and no valid_out follows.
- Accepted write (push=1, full=0): mem[wr_ptr] <= data_in, then wr_ptr+1.
- Accepted read (pop=1, empty=0): data_out <= mem[rd_ptr], valid_out <= 1, then rd_ptr+1.
- Any cycle without an accepted read: valid_out <= 0 and data_out holds its value.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: pop accepted and push accepted, because the slot is freed on the same edge. count stays at depth and error is not set.
  - Empty: push accepted, pop rejected. No read-through bypass. error <= 1 (underflow). count becomes 1.
- Overflow: push=1 with full=1 and pop=0. Word dropped, pointers unchanged, error <= 1.
- Underflow: pop=1 with empty=1. No pointer change, valid_out <= 0, error <= 1.
- error stays set until reset.
- Flags empty, full, almost_full and almost_empty are combinational compares on registered count, so they never glitch within a cycle relative to count.
- Thresholds are unsigned compares. A threshold above depth makes that flag constant (almost_full=0, almost_empty=1).

## Timing
- Write-to-visible: a word pushed on edge N raises count and clears empty after edge N. It can be popped on edge N+1 or later.
- Read latency 1: pop on edge N gives data_out and valid_out=1 during cycle N..N+1.
  - This matches the arbiter's POP→TRAN sequence: data is stable in TRAN and through PUSH, because data_out holds when there is no read.
- full deasserts the cycle after the edge that accepts a pop. The arbiter's single-cycle push is never lost when it checks full in WAIT.
- Back-to-back pops every cycle drain one word per cycle, with valid_out held at 1 throughout.

## Test plan
- Reset then fill: reset=0 for 2 cycles, then push 0x11, 0x22, 0x33, 0x04.
  - After the 4th edge: count=4, full=1, almost_full=1 with th=3.
  - Then pop ×4: data_out sequence 0x11, 0x22, 0x33, 0x04, each one cycle after its pop, with valid_out=1.
  - After that: empty=1.
- Overflow: on a full FIFO, push 0x3F with pop=0.
  - Required: count stays 4, error=1.
  - Subsequent pops return the original 4 words; 0x3F never appears.
- Underflow and empty simultaneous: on an empty FIFO, push 0x05 and pop together.
  - Required: count=1, valid_out=0, error=1.
  - Next pop returns 0x05.
- Full simultaneous plus wrap: fill to 4, then push 0x2A and pop together.
  - Required: count=4, error=0, data_out=first word.
  - Keep popping: 0x2A is returned last, after the pointers have wrapped.
- Reset mid-operation: with count=3, assert reset=0 while pop=1.
  - Required next cycle: count=0, valid_out=0, data_out=0, empty=1, error=0.
- Thresholds: with almost_empty_th=1 and almost_full_th=3, step count 0→4.
  - almost_empty: 1,1,0,0,0.
  - almost_full: 0,0,0,1,1.
